bus_cycle_control: RTL and testbench

BUS_CYCLE_CONTROL -- requirements
Module: bus_cycle_control
Interface
REQ-001 Parameter AW, default 16: address bus width.
REQ-002 Parameter DW, default 8: data bus width.
REQ-003 Parameter WAITW, default 3: width of programmed wait count.
REQ-004 Parameter IO_AUTO_WAIT, default 1: IO cycles SHALL get one automatic TW when 1, none when 0.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 nreset  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  1  bus cycle request.
REQ-008 req_type  input  3  cycle type: 0 fetch, 1 mread, 2 mwrite, 3 ioread, 4 iowrite; codes 5-7 never accepted.
REQ-009 req_addr  input  AW  cycle address.
REQ-010 req_wdata  input  DW  write data.
REQ-011 req_ready  output  1  request accepted on cycles where req_valid & req_ready.
REQ-012 wait_cfg  input  WAITW  programmed wait states per cycle, sampled at acceptance.
REQ-013 nwait  input  1  external wait pin, active-low, synchronous to clk.
REQ-014 db_in  input  DW  data bus pin input.
REQ-015 ab_out  output  AW  address to address-bus pin latch.
REQ-016 db_out  output  DW  data to data-bus pin driver.
REQ-017 bus_ab_pin_we  output  1  address pin latch write enable.
REQ-018 bus_db_pin_oe  output  1  data pin output enable.
REQ-019 bus_db_pin_re  output  1  data pin read (sample) enable.
REQ-020 t_state  output  5  one-hot {T4,T3,TW,T2,T1}; all zero in IDLE.
REQ-021 rd_data  output  DW  captured read data.
REQ-022 rd_valid  output  1  one-cycle pulse, rd_data valid.
Function
REQ-023 States IDLE, T1, T2, TW, T3, T4; cycle length: fetch T1 T2 [TW*] T3 T4; mread/mwrite T1 T2 [TW*] T3; ioread/iowrite T1 T2 TW(auto) [TW*] T3.
REQ-024 req_ready SHALL be 1 in IDLE and in the final T-state of a cycle (T4 fetch, T3 others), else 0; acceptance there enters T1 next clock (zero-bubble back-to-back); no acceptance returns to IDLE.
REQ-025 Accepted type, address, wdata and wait_cfg SHALL be registered; later input changes SHALL not affect the cycle in flight.
REQ-026 Wait counter loads wait_cfg (plus 1 for IO when IO_AUTO_WAIT=1) in T1; T2->TW while counter>0 or nwait=0, each TW decrements a nonzero counter; leave TW->T3 only when counter=0 and nwait=1 sampled that clock.
REQ-027 bus_ab_pin_we SHALL be 1 in T1 for every cycle type; ab_out holds registered address from T1 to cycle end.
REQ-028 bus_db_pin_oe SHALL be 1 in T2, TW and T3 of mwrite/iowrite, 0 otherwise; db_out = registered wdata.
REQ-029 bus_db_pin_re SHALL be 1 in T3 of fetch/mread/ioread; rd_data captures db_in at that clock edge and rd_valid pulses the following clock.
REQ-030 wait_cfg = 2^WAITW-1 SHALL yield exactly that many TW with nwait=1; nwait held low SHALL stall in TW indefinitely.
REQ-031 Unsupported req_type (5-7) SHALL leave req_ready asserted, not start a cycle, and hold state.
Reset
REQ-032 nreset low, including mid-cycle, SHALL immediately force IDLE, t_state=0, all pin enables 0, rd_valid=0, rd_data=0, ab_out=0, db_out=0, wait counter 0, refresh counter 0; req_ready=1 after release.
Configuration
REQ-033 With BUS_REFRESH_EN defined: in fetch T3 and T4, ab_out = {zeros, rfsh[6:0]}, bus_ab_pin_we=1 in T3, and 7-bit rfsh increments at T4 exit, wrapping 127->0.
REQ-034 Without BUS_REFRESH_EN: no refresh counter; fetch T3/T4 keep fetch address and bus_ab_pin_we=0.
Structure
REQ-035 Shared package holds the cycle-type enum and T-state enum; AW/DW/WAITW stay module parameters.
REQ-036 Sub-module bus_wait_counter (load, decrement, zero flag) is natural; the rest is one FSM.
Verification
REQ-037 Fetch addr 0x1234, wait_cfg 0, nwait 1: t_state T1,T2,T3,T4; ab_we T1 only; re in T3; rd_valid next clock with db_in 0xA5.
REQ-038 Mwrite 0x8000 data 0x3C, wait_cfg 2: T1,T2,TW,TW,T3; oe=1 for T2..T3; db_out 0x3C.
REQ-039 Ioread wait_cfg 0, nwait low 3 clocks from T2: exactly 1 auto TW plus extension until nwait=1, then T3 with re=1.
REQ-040 Back-to-back mread then mwrite held valid: no IDLE between, T1 of second follows T3 of first.
REQ-041 nreset asserted in TW of iowrite: outputs all zero same clock, IDLE after release.
REQ-042 BUS_REFRESH_EN: 128 fetches -> refresh address 0..127 then 0, ab_we=1 in each fetch T3.

---
 rtl/bus_cycle_control_pkg.sv | 40 ++++
 rtl/bus_cycle_control_wait_counter.sv | 30 +++
 rtl/bus_cycle_control.sv | 138 +++++++++++++
 tb/tb_bus_cycle_control.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_cycle_control_pkg.sv
// Shared types for the bus cycle controller: cycle-type and T-state encodings.
package bus_cycle_control_pkg;

  typedef enum logic [2:0] {
    CYC_FETCH   = 3'd0,
    CYC_MREAD   = 3'd1,
    CYC_MWRITE  = 3'd2,
    CYC_IOREAD  = 3'd3,
    CYC_IOWRITE = 3'd4
  } cyc_type_e;

  // One-hot {T4,T3,TW,T2,T1}; IDLE is all zero so t_state is the state itself.
  typedef enum logic [4:0] {
    ST_IDLE = 5'b00000,
    ST_T1   = 5'b00001,
    ST_T2   = 5'b00010,
    ST_TW   = 5'b00100,
    ST_T3   = 5'b01000,
    ST_T4   = 5'b10000
  } t_state_e;

  localparam int unsigned RFSH_W = 7;

  function automatic logic type_supported(input logic [2:0] t);
    return (t <= 3'd4);
  endfunction

  function automatic logic is_read(input cyc_type_e t);
    return (t == CYC_FETCH) || (t == CYC_MREAD) || (t == CYC_IOREAD);
  endfunction

  function automatic logic is_write(input cyc_type_e t);
    return (t == CYC_MWRITE) || (t == CYC_IOWRITE);
  endfunction

  function automatic logic is_io(input cyc_type_e t);
    return (t == CYC_IOREAD) || (t == CYC_IOWRITE);
  endfunction

endpackage

// File: rtl/bus_cycle_control_wait_counter.sv
// Wait-state counter: loads a count, decrements while nonzero, flags 0 and 1.
module bus_wait_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          dec,
  output logic          zero,
  output logic          one
);

  logic [CW-1:0] count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
  assign one  = (count == CW'(1));

endmodule

// File: rtl/bus_cycle_control.sv
// Bus cycle controller: sequences T1/T2/TW/T3/T4 for fetch, memory and IO
// cycles and drives the address/data pin controls.
// Optional feature: define BUS_REFRESH_EN to emit a 7-bit refresh address
// during fetch T3/T4.
module bus_cycle_control
  import bus_cycle_control_pkg::*;
#(
  parameter int unsigned AW           = 16,
  parameter int unsigned DW           = 8,
  parameter int unsigned WAITW        = 3,
  parameter int unsigned IO_AUTO_WAIT = 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             req_valid,
  input  logic [2:0]       req_type,
  input  logic [AW-1:0]    req_addr,
  input  logic [DW-1:0]    req_wdata,
  output logic             req_ready,
  input  logic [WAITW-1:0] wait_cfg,
  input  logic             nwait,
  input  logic [DW-1:0]    db_in,
  output logic [AW-1:0]    ab_out,
  output logic [DW-1:0]    db_out,
  output logic             bus_ab_pin_we,
  output logic             bus_db_pin_oe,
  output logic             bus_db_pin_re,
  output logic [4:0]       t_state,
  output logic [DW-1:0]    rd_data,
  output logic             rd_valid
);

  t_state_e         state, state_next;
  cyc_type_e        type_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [WAITW-1:0] wait_q;
  logic             accept;
  logic             auto_w;
  logic [WAITW:0]   load_val;
  logic             cnt_zero, cnt_one;

`ifdef BUS_REFRESH_EN
  logic [RFSH_W-1:0] rfsh;
`endif

  assign auto_w   = (IO_AUTO_WAIT != 0) && is_io(type_q);
  assign load_val = {1'b0, wait_q} + {{WAITW{1'b0}}, auto_w};

  bus_wait_counter #(.CW(WAITW + 1)) u_wait (
    .clk        (clk),
    .nreset     (nreset),
    .load       (state == ST_T1),
    .load_value (load_val),
    .dec        (state == ST_TW),
    .zero       (cnt_zero),
    .one        (cnt_one)
  );

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Capture the accepted request so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      type_q  <= CYC_FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      wait_q  <= '0;
    end else if (accept) begin
      type_q  <= cyc_type_e'(req_type);
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wait_q  <= wait_cfg;
    end
  end

  // Sample the data bus in read T3; flag it valid on the following clock.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= bus_db_pin_re;
      if (bus_db_pin_re) rd_data <= db_in;
    end
  end

`ifdef BUS_REFRESH_EN
  // Refresh address advances once per completed fetch.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)              rfsh <= '0;
    else if (state == ST_T4)  rfsh <= rfsh + 1'b1;
  end
`endif

  // Next-state and acceptance.
  always_comb begin
    state_next = state;
    req_ready  = (state == ST_IDLE) || (state == ST_T4) ||
                 ((state == ST_T3) && (type_q != CYC_FETCH));
    accept     = req_valid && req_ready && type_supported(req_type);
    case (state)
      ST_IDLE: if (accept) state_next = ST_T1;
      ST_T1:   state_next = ST_T2;
      ST_T2:   state_next = (!cnt_zero || !nwait) ? ST_TW : ST_T3;
      // Exit is judged on the post-decrement count, so a load of N gives N TWs.
      ST_TW:   if ((cnt_zero || cnt_one) && nwait) state_next = ST_T3;
      ST_T3: begin
        if (type_q == CYC_FETCH) state_next = ST_T4;
        else                     state_next = accept ? ST_T1 : ST_IDLE;
      end
      ST_T4:   state_next = accept ? ST_T1 : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Pin controls and bus outputs.
  always_comb begin
    t_state       = state;
    ab_out        = addr_q;
    db_out        = wdata_q;
    bus_ab_pin_we = (state == ST_T1);
    bus_db_pin_oe = is_write(type_q) &&
                    ((state == ST_T2) || (state == ST_TW) || (state == ST_T3));
    bus_db_pin_re = is_read(type_q) && (state == ST_T3);
`ifdef BUS_REFRESH_EN
    if ((type_q == CYC_FETCH) && ((state == ST_T3) || (state == ST_T4))) begin
      ab_out = {{(AW - RFSH_W){1'b0}}, rfsh};
      if (state == ST_T3) bus_ab_pin_we = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_bus_cycle_control.sv
// Scoreboard bench for bus_cycle_control: per-clock expected T-state traces
// are queued at issue time and checked by an independent monitor.
module tb_bus_cycle_control;

  localparam logic [4:0] S_T1 = 5'b00001;
  localparam logic [4:0] S_T2 = 5'b00010;
  localparam logic [4:0] S_TW = 5'b00100;
  localparam logic [4:0] S_T3 = 5'b01000;
  localparam logic [4:0] S_T4 = 5'b10000;

  typedef struct packed {
    logic [4:0]  ts;
    logic        we;
    logic        oe;
    logic        re;
    logic        rdy;
    logic [15:0] ab;
    logic [7:0]  db;
  } obs_t;

  logic        clk, nreset, req_valid, req_ready, nwait;
  logic [2:0]  req_type;
  logic [15:0] req_addr, ab_out;
  logic [7:0]  req_wdata, db_in, db_out, rd_data;
  logic [2:0]  wait_cfg;
  logic        bus_ab_pin_we, bus_db_pin_oe, bus_db_pin_re, rd_valid;
  logic [4:0]  t_state;

  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  bit   mon_en = 0;
  logic [6:0] rfsh_exp = '0;
  obs_t exp_q[$];
  logic [7:0] rd_q[$];

  bus_cycle_control #(.AW(16), .DW(8), .WAITW(3), .IO_AUTO_WAIT(1)) dut (
    .clk           (clk),
    .nreset        (nreset),
    .req_valid     (req_valid),
    .req_type      (req_type),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .wait_cfg      (wait_cfg),
    .nwait         (nwait),
    .db_in         (db_in),
    .ab_out        (ab_out),
    .db_out        (db_out),
    .bus_ab_pin_we (bus_ab_pin_we),
    .bus_db_pin_oe (bus_db_pin_oe),
    .bus_db_pin_re (bus_db_pin_re),
    .t_state       (t_state),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  function automatic obs_t mk(logic [4:0] ts, logic we, logic oe, logic re,
                              logic rdy, logic [15:0] ab, logic [7:0] db);
    obs_t o;
    o.ts = ts; o.we = we; o.oe = oe; o.re = re; o.rdy = rdy; o.ab = ab; o.db = db;
    return o;
  endfunction

  // Queue the expected per-clock trace of one cycle with ntw wait states.
  task automatic push_cycle(input logic [2:0] ty, input logic [15:0] a,
                            input logic [7:0] wd, input int ntw, input logic [7:0] dbv);
    bit rd, wr, fe, fe_we;
    logic [15:0] fab;
    rd = (ty == 3'd0) || (ty == 3'd1) || (ty == 3'd3);
    wr = (ty == 3'd2) || (ty == 3'd4);
    fe = (ty == 3'd0);
    fab = a;
    fe_we = 1'b0;
`ifdef BUS_REFRESH_EN
    if (fe) begin
      fab = {9'd0, rfsh_exp};
      fe_we = 1'b1;
    end
`endif
    exp_q.push_back(mk(S_T1, 1'b1, 1'b0, 1'b0, 1'b0, a, wd));
    exp_q.push_back(mk(S_T2, 1'b0, wr, 1'b0, 1'b0, a, wd));
    for (int i = 0; i < ntw; i++) exp_q.push_back(mk(S_TW, 1'b0, wr, 1'b0, 1'b0, a, wd));
    exp_q.push_back(mk(S_T3, fe_we, wr, rd, !fe, fe ? fab : a, wd));
    if (fe) begin
      exp_q.push_back(mk(S_T4, 1'b0, 1'b0, 1'b0, 1'b1, fab, wd));
      rfsh_exp = rfsh_exp + 1'b1;
    end
    if (rd) rd_q.push_back(dbv);
  endtask

  // Present a request and hold it until the edge that accepts it.
  task automatic issue(input logic [2:0] ty, input logic [15:0] a,
                       input logic [7:0] wd, input logic [2:0] wc);
    bit ok;
    req_type = ty; req_addr = a; req_wdata = wd; wait_cfg = wc; req_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL issue_timeout: req_ready=%0b, required 1 within 64 clocks", req_ready);
    end else begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_t_state"}, 32'(t_state), 32'd0);
    chk({tag, "_ab_we"},   32'(bus_ab_pin_we), 32'd0);
    chk({tag, "_db_oe"},   32'(bus_db_pin_oe), 32'd0);
    chk({tag, "_db_re"},   32'(bus_db_pin_re), 32'd0);
    chk({tag, "_rd_valid"},32'(rd_valid), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_ab_out"},  32'(ab_out), 32'd0);
    chk({tag, "_db_out"},  32'(db_out), 32'd0);
  endtask

  // Monitor: every active T-state and every rd_valid pulse is popped and compared.
  initial begin
    obs_t cur, e;
    logic [7:0] er;
    forever begin
      @(negedge clk);
      if (mon_en && nreset) begin
        if (t_state != 5'd0) begin
          cur = mk(t_state, bus_ab_pin_we, bus_db_pin_oe, bus_db_pin_re, req_ready, ab_out, db_out);
          nvec++;
          if (exp_q.size() == 0) begin
            nerr++;
            $display("FAIL trace_unexpected: got ts=%b we=%b oe=%b re=%b rdy=%b ab=%h db=%h, expected IDLE",
                     cur.ts, cur.we, cur.oe, cur.re, cur.rdy, cur.ab, cur.db);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              nerr++;
              $display("FAIL trace: got ts=%b we=%b oe=%b re=%b rdy=%b ab=%h db=%h, expected ts=%b we=%b oe=%b re=%b rdy=%b ab=%h db=%h",
                       cur.ts, cur.we, cur.oe, cur.re, cur.rdy, cur.ab, cur.db,
                       e.ts, e.we, e.oe, e.re, e.rdy, e.ab, e.db);
            end
          end
        end
        if (rd_valid) begin
          nvec++;
          if (rd_q.size() == 0) begin
            nerr++;
            $display("FAIL rd_unexpected: got rd_data=%h, expected no rd_valid", rd_data);
          end else begin
            er = rd_q.pop_front();
            if (rd_data !== er) begin
              nerr++;
              $display("FAIL rd_data: got %h, expected %h", rd_data, er);
            end
          end
        end
      end
    end
  end

  initial begin
    int c1;
    nreset = 1'b1; req_valid = 1'b0; req_type = 3'd0; req_addr = '0; req_wdata = '0;
    wait_cfg = '0; nwait = 1'b1; db_in = '0;
    #1 nreset = 1'b0;
    #7 chk_all_zero("reset");
    @(negedge clk); nreset = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Fetch, no waits.
    db_in = 8'hA5;
    push_cycle(3'd0, 16'h1234, 8'h00, 0, 8'hA5);
    issue(3'd0, 16'h1234, 8'h00, 3'd0);
    req_valid = 1'b0;
    repeat (6) @(posedge clk); #1;

    // Memory write with two programmed waits; inputs scrambled after acceptance.
    push_cycle(3'd2, 16'h8000, 8'h3C, 2, 8'h00);
    issue(3'd2, 16'h8000, 8'h3C, 3'd2);
    req_valid = 1'b0; req_addr = 16'hFFFF; req_wdata = 8'hFF; wait_cfg = 3'd7;
    repeat (8) @(posedge clk); #1;

    // IO read, nwait low for three clocks starting in T2.
    db_in = 8'h5A;
    push_cycle(3'd3, 16'h0042, 8'h00, 3, 8'h5A);
    issue(3'd3, 16'h0042, 8'h00, 3'd0);
    req_valid = 1'b0;
    @(posedge clk); #1 nwait = 1'b0;
    repeat (3) @(posedge clk); #1 nwait = 1'b1;
    repeat (6) @(posedge clk); #1;

    // IO write, only the automatic wait.
    push_cycle(3'd4, 16'h0010, 8'h99, 1, 8'h00);
    issue(3'd4, 16'h0010, 8'h99, 3'd0);
    req_valid = 1'b0;
    repeat (6) @(posedge clk); #1;

    // Maximum programmed wait.
    db_in = 8'hC3;
    push_cycle(3'd1, 16'h2000, 8'h00, 7, 8'hC3);
    issue(3'd1, 16'h2000, 8'h00, 3'd7);
    req_valid = 1'b0;
    repeat (12) @(posedge clk); #1;

    // Memory read, wait 1, nwait low for six clocks from T2.
    db_in = 8'h7E;
    push_cycle(3'd1, 16'h3003, 8'h00, 6, 8'h7E);
    issue(3'd1, 16'h3003, 8'h00, 3'd1);
    req_valid = 1'b0;
    @(posedge clk); #1 nwait = 1'b0;
    repeat (6) @(posedge clk); #1 nwait = 1'b1;
    repeat (6) @(posedge clk); #1;

    // Back-to-back mread then mwrite with valid held.
    db_in = 8'h6B;
    push_cycle(3'd1, 16'h0100, 8'h11, 1, 8'h6B);
    push_cycle(3'd2, 16'h0200, 8'h22, 0, 8'h00);
    issue(3'd1, 16'h0100, 8'h11, 3'd1);
    c1 = cyc;
    issue(3'd2, 16'h0200, 8'h22, 3'd0);
    chk("b2b_spacing", 32'(cyc - c1), 32'd4);
    req_valid = 1'b0;
    repeat (6) @(posedge clk); #1;

    // Unsupported types are never accepted.
    for (int t = 5; t <= 7; t++) begin
      req_type = 3'(t); req_valid = 1'b1;
      @(negedge clk);
      chk("bad_type_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      chk("bad_type_idle", 32'(t_state), 32'd0);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("queue_drained_pre_reset", 32'(exp_q.size() + rd_q.size()), 32'd0);

    // Reset in TW of an IO write.
    mon_en = 1'b0;
    issue(3'd4, 16'h0ABC, 8'h77, 3'd3);
    req_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("pre_reset_tw", 32'(t_state), 32'(S_TW));
    #2 nreset = 1'b0;
    #1 chk_all_zero("midreset");
    rfsh_exp = '0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 32'(t_state), 32'd0);
    chk("post_reset_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    mon_en = 1'b1;

`ifdef BUS_REFRESH_EN
    // 129 back-to-back fetches: refresh address walks 0..127 then wraps to 0.
    db_in = 8'hA5;
    for (int i = 0; i < 129; i++) push_cycle(3'd0, 16'(i), 8'h00, 0, 8'hA5);
    for (int i = 0; i < 129; i++) issue(3'd0, 16'(i), 8'h00, 3'd0);
    req_valid = 1'b0;
    repeat (6) @(posedge clk); #1;
`endif

    // Recovery fetch after reset.
    db_in = 8'h3E;
    push_cycle(3'd0, 16'h00FF, 8'h00, 0, 8'h3E);
    issue(3'd0, 16'h00FF, 8'h00, 3'd0);
    req_valid = 1'b0;
    repeat (10) @(posedge clk); #1;

    chk("trace_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
